// File: rtl/counter_pkg.sv
// Shared types and defaults for the counter sequencer and its prescaler.
package counter_pkg;

  localparam int unsigned NDefault    = 8;
  localparam int unsigned PwDefault   = 23;
  localparam int unsigned DIV_DEFAULT = 7400000;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StRun,
    StHold,
    StDone
  } state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Reloadable divider: counts 0..div_i while enabled and strobes expire_o on the
// terminal count, reloading to 0 in the same cycle.
module tick_prescaler #(
  parameter int unsigned PW = 23
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  input  logic          load_i,
  input  logic [PW-1:0] div_i,
  output logic          expire_o
);

  logic [PW-1:0] cnt_q, cnt_d;

  assign expire_o = en_i && (cnt_q == div_i);

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = expire_o ? '0 : cnt_q + PW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/counter_seq_ctrl.sv
// Start/stop sequencer for the binary counter: paces step/clr strobes with a run-time divisor.
// Define COUNTER_SEQ_PAUSE_EN to turn stop-in-run into a resumable pause (HOLD state).
module counter_seq_ctrl
  import counter_pkg::*;
#(
  parameter int unsigned N  = NDefault,
  parameter int unsigned PW = PwDefault
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic          stop_i,
  input  logic          clear_i,
  input  logic [PW-1:0] div_i,
  input  logic [N-1:0]  limit_i,
  input  logic          auto_reload_i,
  output logic          busy_o,
  output logic          step_o,
  output logic          clr_o,
  output logic [N-1:0]  value_o,
  output logic          done_o
);

  state_e        state_q, state_d;
  logic [N-1:0]  value_q, value_d;
  logic [N-1:0]  limit_q, limit_d;
  logic [PW-1:0] div_q, div_d;
  logic          ar_q, ar_d;
  logic          busy_q, busy_d;
  logic          step_q, step_d;
  logic          clr_q, clr_d;
  logic          done_q, done_d;

  logic          idle_or_done;
  logic          finishing;
  logic          ps_en, ps_load, ps_expire;

  // A one-shot run signals done while still in RUN; the following cycle retires it to DONE.
  assign finishing    = (state_q == StRun) && done_q && !ar_q;
  assign idle_or_done = (state_q == StIdle) || (state_q == StDone);
  assign ps_en        = !clear_i && !stop_i &&
                        ((state_q == StArm) || ((state_q == StRun) && !finishing));
  assign ps_load      = clear_i || (!stop_i && start_i && idle_or_done);

  tick_prescaler #(
    .PW(PW)
  ) u_prescaler (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    (ps_en),
    .load_i  (ps_load),
    .div_i   (div_q),
    .expire_o(ps_expire)
  );

  always_comb begin
    state_d = state_q;
    value_d = value_q;
    limit_d = limit_q;
    div_d   = div_q;
    ar_d    = ar_q;
    step_d  = 1'b0;
    clr_d   = 1'b0;
    done_d  = 1'b0;
    if (clear_i) begin
      state_d = StIdle;
      value_d = '0;
      clr_d   = 1'b1;
    end else if (stop_i) begin
`ifdef COUNTER_SEQ_PAUSE_EN
      state_d = ((state_q == StRun) && !finishing) ? StHold : StIdle;
`else
      state_d = StIdle;
`endif
    end else if (start_i && idle_or_done) begin
      state_d = StArm;
      value_d = '0;
      clr_d   = 1'b1;
      div_d   = div_i;
      limit_d = limit_i;
      ar_d    = auto_reload_i;
`ifdef COUNTER_SEQ_PAUSE_EN
    end else if (start_i && (state_q == StHold)) begin
      state_d = StRun;
`endif
    end else begin
      case (state_q)
        StArm, StRun: begin
          if (finishing) begin
            state_d = StDone;
          end else begin
            state_d = StRun;
            if (ps_expire) begin
              if (value_q != limit_q) begin
                value_d = value_q + N'(1);
                step_d  = 1'b1;
              end else begin
                done_d = 1'b1;
                if (ar_q) begin
                  value_d = '0;
                  clr_d   = 1'b1;
                end
              end
            end
          end
        end
        default: ;
      endcase
    end
    busy_d = (state_d == StArm) || (state_d == StRun) || (state_d == StHold);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      value_q <= '0;
      limit_q <= '0;
      div_q   <= '0;
      ar_q    <= 1'b0;
      busy_q  <= 1'b0;
      step_q  <= 1'b0;
      clr_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      limit_q <= limit_d;
      div_q   <= div_d;
      ar_q    <= ar_d;
      busy_q  <= busy_d;
      step_q  <= step_d;
      clr_q   <= clr_d;
      done_q  <= done_d;
    end
  end

  assign busy_o  = busy_q;
  assign step_o  = step_q;
  assign clr_o   = clr_q;
  assign done_o  = done_q;
  assign value_o = value_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed self-checking bench for counter_seq_ctrl; flags are compared as {busy,step,clr,done}.
module tb_counter_seq_ctrl;
  import counter_pkg::*;

  localparam int unsigned N  = 8;
  localparam int unsigned PW = 23;

  logic          clk = 1'b0;
  logic          rst_n, start, stop, clear, ar;
  logic [PW-1:0] div;
  logic [N-1:0]  limit;
  logic          busy, step, clr, done;
  logic [N-1:0]  value;
  int            n_checks = 0;
  int            n_errors = 0;

  always #5 clk = ~clk;

  counter_seq_ctrl #(
    .N (N),
    .PW(PW)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .stop_i       (stop),
    .clear_i      (clear),
    .div_i        (div),
    .limit_i      (limit),
    .auto_reload_i(ar),
    .busy_o       (busy),
    .step_o       (step),
    .clr_o        (clr),
    .value_o      (value),
    .done_o       (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; ar = 1'b0; div = '0; limit = '0;
    tick(); tick();
    n_checks++;
    if ({busy, step, clr, done} !== 4'b0000 || value !== 8'd0) begin
      n_errors++;
      $display("FAIL reset: flags=%b value=%0d want 0000/0", {busy, step, clr, done}, value);
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if ({busy, step, clr, done} !== 4'b0000 || value !== 8'd0) begin
      n_errors++;
      $display("FAIL reset_idle: flags=%b value=%0d want 0000/0", {busy, step, clr, done}, value);
    end
  endtask

  task automatic test_oneshot();
    logic [3:0]   exp_f;
    logic [N-1:0] exp_v;
    div = 23'd3; limit = 8'd5; ar = 1'b0; start = 1'b1;
    tick();
    n_checks++;
    if ({busy, step, clr, done} !== 4'b1010 || value !== 8'd0) begin
      n_errors++;
      $display("FAIL oneshot_arm: flags=%b value=%0d want 1010/0", {busy, step, clr, done}, value);
    end
    // Settings changed after start must be ignored; start is also held while busy.
    div = 23'd0; limit = 8'd1; ar = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      for (int c = 1; c <= 4; c++) begin
        tick();
        if (k == 1 && c == 2) start = 1'b0;
        exp_v = (c == 4 && k <= 5) ? N'(k) : N'(k - 1);
        exp_f = {1'b1, (c == 4 && k <= 5), 1'b0, (c == 4 && k == 6)};
        n_checks++;
        if ({busy, step, clr, done} !== exp_f || value !== exp_v) begin
          n_errors++;
          $display("FAIL oneshot_run k=%0d c=%0d: flags=%b value=%0d want %b/%0d",
                   k, c, {busy, step, clr, done}, value, exp_f, exp_v);
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if ({busy, step, clr, done} !== 4'b0000 || value !== 8'd5) begin
        n_errors++;
        $display("FAIL oneshot_done_hold %0d: flags=%b value=%0d want 0000/5",
                 i, {busy, step, clr, done}, value);
      end
    end
  endtask

  task automatic test_auto_reload();
    logic [3:0]   exp_f;
    logic [N-1:0] exp_v;
    div = 23'd0; limit = 8'd2; ar = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if ({busy, step, clr, done} !== 4'b1010 || value !== 8'd0) begin
      n_errors++;
      $display("FAIL reload_arm: flags=%b value=%0d want 1010/0", {busy, step, clr, done}, value);
    end
    for (int i = 1; i <= 12; i++) begin
      tick();
      exp_v = N'(i % 3);
      exp_f = {1'b1, exp_v != 0, exp_v == 0, exp_v == 0};
      n_checks++;
      if ({busy, step, clr, done} !== exp_f || value !== exp_v) begin
        n_errors++;
        $display("FAIL reload_seq i=%0d: flags=%b value=%0d want %b/%0d",
                 i, {busy, step, clr, done}, value, exp_f, exp_v);
      end
      n_checks++;
      if ((step & clr) !== 1'b0) begin
        n_errors++;
        $display("FAIL reload_excl i=%0d: step&clr=%b want 0", i, step & clr);
      end
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_checks++;
    if ({busy, step, clr, done} !== 4'b0010 || value !== 8'd0) begin
      n_errors++;
      $display("FAIL reload_clear: flags=%b value=%0d want 0010/0", {busy, step, clr, done}, value);
    end
  endtask

  task automatic test_wrap();
    logic [3:0]   exp_f;
    logic [N-1:0] exp_v;
    logic         wrap;
    div = 23'd0; limit = 8'd255; ar = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 257; i++) begin
      tick();
      exp_v = N'(i % 256);
      wrap  = (i == 256);
      exp_f = {1'b1, !wrap, wrap, wrap};
      n_checks++;
      if ({busy, step, clr, done} !== exp_f || value !== exp_v) begin
        n_errors++;
        $display("FAIL wrap i=%0d: flags=%b value=%0d want %b/%0d",
                 i, {busy, step, clr, done}, value, exp_f, exp_v);
      end
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_stop_start();
    div = 23'd3; limit = 8'd10; ar = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    n_checks++;
    if ({busy, step, clr, done} !== 4'b1100 || value !== 8'd2) begin
      n_errors++;
      $display("FAIL stop_pre: flags=%b value=%0d want 1100/2", {busy, step, clr, done}, value);
    end
    repeat (2) tick();
    stop = 1'b1; start = 1'b1;
    tick();
    stop = 1'b0; start = 1'b0;
`ifdef COUNTER_SEQ_PAUSE_EN
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if ({busy, step, clr, done} !== 4'b1000 || value !== 8'd2) begin
        n_errors++;
        $display("FAIL hold %0d: flags=%b value=%0d want 1000/2", i, {busy, step, clr, done}, value);
      end
      tick();
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({busy, step, clr, done} !== ((i == 2) ? 4'b1100 : 4'b1000) ||
          value !== ((i == 2) ? 8'd3 : 8'd2)) begin
        n_errors++;
        $display("FAIL resume %0d: flags=%b value=%0d", i, {busy, step, clr, done}, value);
      end
      if (i < 2) tick();
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
`else
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if ({busy, step, clr, done} !== 4'b0000 || value !== 8'd2) begin
        n_errors++;
        $display("FAIL stop_idle %0d: flags=%b value=%0d want 0000/2",
                 i, {busy, step, clr, done}, value);
      end
      tick();
    end
`endif
  endtask

  task automatic test_clear_boundary();
    div = 23'd1; limit = 8'd3; ar = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    n_checks++;
    if ({busy, step, clr, done} !== 4'b1100 || value !== 8'd3) begin
      n_errors++;
      $display("FAIL clrb_pre: flags=%b value=%0d want 1100/3", {busy, step, clr, done}, value);
    end
    tick();
    // This cycle is the terminal-count boundary that would otherwise raise done.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_checks++;
    if ({busy, step, clr, done} !== 4'b0010 || value !== 8'd0) begin
      n_errors++;
      $display("FAIL clrb: flags=%b value=%0d want 0010/0", {busy, step, clr, done}, value);
    end
    tick();
    n_checks++;
    if ({busy, step, clr, done} !== 4'b0000 || value !== 8'd0) begin
      n_errors++;
      $display("FAIL clrb_after: flags=%b value=%0d want 0000/0", {busy, step, clr, done}, value);
    end
  endtask

  task automatic test_reset_midrun();
    div = PW'(DIV_DEFAULT); limit = 8'd3; ar = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    n_checks++;
    if (busy !== 1'b1) begin
      n_errors++;
      $display("FAIL rstmid_busy: busy=%b want 1", busy);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++;
    if ({busy, step, clr, done} !== 4'b0000 || value !== 8'd0) begin
      n_errors++;
      $display("FAIL rstmid: flags=%b value=%0d want 0000/0", {busy, step, clr, done}, value);
    end
    div = 23'd1; limit = 8'd1; start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if ({busy, step, clr, done} !== 4'b1010 || value !== 8'd0) begin
      n_errors++;
      $display("FAIL rstmid_arm: flags=%b value=%0d want 1010/0", {busy, step, clr, done}, value);
    end
    tick(); tick();
    n_checks++;
    if ({busy, step, clr, done} !== 4'b1100 || value !== 8'd1) begin
      n_errors++;
      $display("FAIL rstmid_step: flags=%b value=%0d want 1100/1", {busy, step, clr, done}, value);
    end
    tick(); tick();
    n_checks++;
    if ({busy, step, clr, done} !== 4'b1001 || value !== 8'd1) begin
      n_errors++;
      $display("FAIL rstmid_done: flags=%b value=%0d want 1001/1", {busy, step, clr, done}, value);
    end
    tick();
    n_checks++;
    if ({busy, step, clr, done} !== 4'b0000 || value !== 8'd1) begin
      n_errors++;
      $display("FAIL rstmid_end: flags=%b value=%0d want 0000/1", {busy, step, clr, done}, value);
    end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_auto_reload();
    test_wrap();
    test_stop_start();
    test_clear_boundary();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/counter_seq_ctrl.md
# counter_seq_ctrl

Sequencer for the free-running binary counter datapath: owns the prescaler that paces counting, and runs the count as a start/stop/pause-controlled job with a programmable terminal value. Sits between the front-panel or button logic and the counter/display path. Drives a one-cycle `step` strobe and a `clr` strobe to the counter, and mirrors the count on `value`. Replaces the hard-coded 7400000-cycle pacing with a run-time divisor and a completion handshake.

## Interface
- `N`, default 8: counter width.
- `PW`, default 23: prescaler width.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-low reset.
- `start`  in  1: level-sampled request; begins a run from IDLE or DONE.
- `stop`  in  1: abort the run, or pause it when `COUNTER_SEQ_PAUSE_EN` is defined.
- `clear`  in  1: force `value` to 0 and return to IDLE.
- `div`  in  PW: pacing divisor, sampled at start. Period between advances = div+1 cycles.
- `limit`  in  N: terminal value, sampled at start.
- `auto_reload`  in  1: sampled at start. 1 = wrap and continue; 0 = one-shot.
- `busy`  out  1: high in ARM, RUN and HOLD.
- `step`  out  1: one-cycle strobe; the counter advances this cycle.
- `clr`  out  1: one-cycle strobe; the counter returns to 0.
- `value`  out  N: current count.
- `done`  out  1: one-cycle pulse when `value` reaches `limit` on a boundary.

## Operation
- States and transitions:
  - IDLE: start → ARM.
  - ARM: one cycle. Latches div/limit/auto_reload, zeroes the prescaler, pulses `clr`, sets `value`=0. Then → RUN.
  - RUN: counts (see pacing and boundary rules below).
  - HOLD: pause state (macro only).
  - DONE: holds `value`. start → ARM; clear → IDLE.
- Pacing in RUN:
  - Prescaler counts 0..div_latched.
  - On expiry (prescaler == div_latched) it reloads to 0. This is a boundary event.
  - Otherwise the prescaler increments.
- On a boundary, when `value` != limit_latched: `value` <= `value`+1 and `step`=1.
- On a boundary, when `value` == limit_latched:
  - auto_reload=1: `value` <= 0, `clr`=1, `done`=1, stay in RUN.
  - auto_reload=0: `done`=1, move to DONE, `value` unchanged.
- limit=0:
  - One-shot: `done` on the first boundary.
  - Auto-reload: `done` on every boundary, `value` stays 0.
- Priority within a cycle: reset > clear > stop > start > boundary.
- clear in any state: `value`=0, `clr`=1, prescaler=0, go to IDLE, no `done`.
- stop in RUN (macro undefined): go to IDLE, `value` held, no strobe.
- start while busy is ignored. Changes to div/limit/auto_reload mid-run have no effect.
- `value` arithmetic is modulo 2^N. With limit = 2^N-1, `done` fires at the max value.
- Only one of `step`/`clr` is high in any cycle.

## Timing
- Reset values: state IDLE, `value`=0, prescaler 0, `busy`=0, `step`=0, `clr`=0, `done`=0.
- All outputs are registered.
- start sampled at edge T:
  - ARM occupies T+1; `busy` and `clr` are high in T+1.
  - RUN begins at T+2.
  - The first boundary is at T+2+div.
- Boundary k (k ≥ 1) occurs at T+2+k·(div+1)-1.
- `step` and the new `value` appear together, in the same cycle.
- `done` coincides with the cycle `value` is at limit on a boundary.
  - One-shot: `busy` falls in the cycle after `done`.
- Reset mid-run: all registers return to reset values at the next edge. No `done` or `step` is emitted.

## Configuration
- `COUNTER_SEQ_PAUSE_EN` defined:
  - HOLD state compiled in. stop in RUN → HOLD; prescaler and `value` are frozen, `busy` stays 1.
  - In HOLD: start → RUN, resuming mid-period with no ARM and no `clr`; stop → IDLE.
- Undefined:
  - No HOLD state. stop always goes to IDLE.

## Structure
- Shared package `counter_pkg`:
  - State enum (IDLE, ARM, RUN, HOLD, DONE).
  - Default `N`/`PW`.
  - `DIV_DEFAULT` = 7400000.
- One sub-module: `tick_prescaler` (PW-bit reloadable divider).
  - Inputs: enable, load, div.
  - Output: expiry strobe.
- The FSM and `value` register live in the top level.

## Test plan
- Reset, then start with div=3, limit=5, one-shot:
  - `clr` in ARM.
  - `step` every 4 cycles; `value` 1..5.
  - `done` once with `value`=5; `busy` low next cycle; `value` holds 5.
- div=0, limit=2, auto_reload=1 for 12 cycles: `value` sequence 1,2,0,1,2,0…; `done` with every `clr`; no cycle has `step` and `clr` together.
- N=8, limit=255, div=0, auto_reload=1: `value` wraps 255→0 with `done`; no overflow beyond 8 bits.
- During RUN, assert stop and start in the same cycle:
  - Macro off: IDLE, `value` held.
  - Macro on: HOLD, then start resumes at the exact prescaler phase with no `clr`.
- clear asserted together with a boundary cycle: `value`=0, `clr`=1, IDLE, no `done`/`step`.
- Reset low for one cycle mid-run with div=7400000: all outputs return to reset values at the next edge; a subsequent start restarts from ARM.
